score_keeper: RTL and testbench

Upstream scoring stage for the score display. It accepts line-clear events from the playfield logic through a valid/ready handshake, buffers up to two of them, and converts each event into points. It maintains the saturating 10-bit score consumed by `score_grid`, plus a line total and level. The score can optionally count up visibly, one point at a time.

---
 rtl/score_keeper.sv | 125 ++++++++++++
 tb/tb_score_keeper.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: buffers line-clear events in a 2-entry FIFO and keeps the saturating score, line total and level.
// Define SCORE_COUNTUP_EN to make the score count up one point every STEP_DIV cycles instead of jumping.
module score_keeper #(
    parameter int STEP_DIV  = 2,
    parameter int MAX_SCORE = 999
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       new_game,
    input  logic       clear_valid,
    input  logic [2:0] lines_cleared,
    output logic       clear_ready,
    output logic [9:0] score,
    output logic [9:0] lines_total,
    output logic [3:0] level,
    output logic       busy
);
`ifdef SCORE_COUNTUP_EN
    typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;
    logic [3:0] pending;
    logic [7:0] step;
    logic       at_max;
`else
    typedef enum logic [1:0] {IDLE, LOAD} state_t;
    logic [10:0] sc_sum;
    logic [9:0]  sc_next;
`endif
    state_t      state;
    logic [2:0]  fifo_mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  fifo_cnt;
    logic        full, empty, push, pop;
    logic [2:0]  head, head_lines;
    logic [3:0]  head_pts;
    logic [10:0] lt_sum;
    logic [9:0]  lt_next, lvl_raw;

    generate
        if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_bad_step_div
            $error("STEP_DIV must be in 1..255");
        end
    endgenerate

    always_comb begin
        full        = fifo_cnt == 2'd2;
        empty       = fifo_cnt == 2'd0;
        clear_ready = !full && !new_game;
        push        = clear_valid && clear_ready;
        pop         = state == LOAD;
        head        = fifo_mem[rd_ptr];
        head_lines  = head > 3'd4 ? 3'd4 : head;
        head_pts    = head_lines == 3'd4 ? 4'd8 :
                      head_lines == 3'd3 ? 4'd5 :
                      head_lines == 3'd2 ? 4'd3 : {3'b0, head_lines == 3'd1};
        lt_sum      = {1'b0, lines_total} + {8'b0, head_lines};
        lt_next     = lt_sum[10] ? 10'd1023 : lt_sum[9:0];
        lvl_raw     = lines_total / 10'd10;
        level       = lvl_raw > 10'd15 ? 4'd15 : lvl_raw[3:0];
        busy        = state != IDLE || !empty;
`ifdef SCORE_COUNTUP_EN
        at_max      = score >= 10'(MAX_SCORE);
`else
        sc_sum      = {1'b0, score} + {7'b0, head_pts};
        sc_next     = sc_sum > 11'(MAX_SCORE) ? 10'(MAX_SCORE) : sc_sum[9:0];
`endif
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n || new_game) begin
            state       <= IDLE;
            score       <= '0;
            lines_total <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= '0;
`ifdef SCORE_COUNTUP_EN
            pending     <= '0;
            step        <= '0;
`endif
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= lines_cleared;
                wr_ptr           <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    lines_total <= lt_next;
`ifdef SCORE_COUNTUP_EN
                    pending <= head_pts;
                    step    <= '0;
                    state   <= head_pts != 4'd0 ? COUNT : IDLE;
`else
                    score <= sc_next;
                    // the entry being popped is still counted, so >1 means another is waiting
                    state <= fifo_cnt > 2'd1 ? LOAD : IDLE;
`endif
                end
`ifdef SCORE_COUNTUP_EN
                COUNT: begin
                    if (at_max) begin
                        pending <= '0;
                        step    <= '0;
                        state   <= empty ? IDLE : LOAD;
                    end else if (step == 8'(STEP_DIV - 1)) begin
                        step    <= '0;
                        score   <= score + 10'd1;
                        pending <= pending - 4'd1;
                        if (pending == 4'd1)
                            state <= empty ? IDLE : LOAD;
                    end else begin
                        step <= step + 8'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scoreboard bench; expected score/line updates are queued with their edge number.
module tb_score_keeper;
    localparam int STEP = 2;

    logic       frame_clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       new_game = 1'b0;
    logic       clear_valid = 1'b0;
    logic [2:0] lines_cleared = 3'd0;
    logic       clear_ready;
    logic [9:0] score, lines_total;
    logic [3:0] level;
    logic       busy;

    score_keeper #(.STEP_DIV(STEP), .MAX_SCORE(999)) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .new_game(new_game),
        .clear_valid(clear_valid), .lines_cleared(lines_cleared),
        .clear_ready(clear_ready), .score(score), .lines_total(lines_total),
        .level(level), .busy(busy)
    );

    always #5 frame_clk = ~frame_clk;

    int cyc = 0;
    always @(posedge frame_clk) cyc <= cyc + 1;

    typedef struct {int c; int s; int l;} exp_t;
    typedef struct {string n; int a; int r;} dchk_t;
    exp_t  exp_q[$];
    dchk_t dq[$];
    int    checks = 0, errors = 0;
    bit    mon_en = 1'b0;
    int    prev_s = 0, prev_l = 0, max_s = 0;

    // Single checking process: drains direct checks, and matches every score/lines change to the next expectation
    always @(negedge frame_clk) begin
        exp_t  e;
        dchk_t d;
        int    lv;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.a != d.r) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", d.n, d.a, d.r);
            end
        end
        if (int'(score) > max_s) max_s = int'(score);
        if (int'(score) != prev_s || int'(lines_total) != prev_l) begin
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: edge %0d score %0d lines %0d, expected no change", cyc, score, lines_total);
                end else begin
                    e  = exp_q.pop_front();
                    lv = e.l / 10 > 15 ? 15 : e.l / 10;
                    if (cyc != e.c || int'(score) != e.s || int'(lines_total) != e.l || int'(level) != lv) begin
                        errors++;
                        $display("FAIL update: got edge %0d score %0d lines %0d level %0d, expected edge %0d score %0d lines %0d level %0d",
                                 cyc, score, lines_total, level, e.c, e.s, e.l, lv);
                    end
                end
            end
            prev_s = int'(score);
            prev_l = int'(lines_total);
        end
    end

    task automatic chk(input string n, input int a, input int r);
        dq.push_back('{n, a, r});
    endtask

    task automatic exp_push(input int c, input int s, input int l);
        exp_q.push_back('{c, s, l});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge frame_clk);
    endtask

    // Offer one event and hold it until accepted; acc is the accepting edge number
    task automatic offer(input logic [2:0] n, output int acc);
        acc = -1;
        @(negedge frame_clk);
        clear_valid = 1'b1;
        lines_cleared = n;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            #1;
            if (clear_ready) begin
                @(posedge frame_clk);
                #1 acc = cyc;
            end else begin
                @(negedge frame_clk);
            end
        end
        clear_valid = 1'b0;
        if (acc < 0) chk("offer_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge frame_clk);
            #1 done = !busy;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    // Expected updates for one event taken from an idle block with starting score s0 and lines l0
    task automatic expect_single(input int acc, input int pts, input int nl, input int s0, input int l0);
`ifdef SCORE_COUNTUP_EN
        if (nl > 0) exp_push(acc + 2, s0, l0 + nl);
        for (int i = 1; i <= pts; i++) exp_push(acc + 2 + STEP * i, s0 + i, l0 + nl);
`else
        if (pts > 0 || nl > 0) exp_push(acc + 2, s0 + pts, l0 + nl);
`endif
    endtask

    task automatic pulse_new_game(input bit expect_change);
        int g;
        @(negedge frame_clk);
        new_game = 1'b1;
        clear_valid = 1'b1;
        lines_cleared = 3'd3;
        #1 chk("ready_during_new_game", int'(clear_ready), 0);
        @(posedge frame_clk);
        #1 g = cyc;
        if (expect_change) exp_push(g, 0, 0);
        @(negedge frame_clk);
        new_game = 1'b0;
        clear_valid = 1'b0;
        #1;
        chk("busy_after_new_game", int'(busy), 0);
        chk("ready_after_new_game", int'(clear_ready), 1);
        chk("score_after_new_game", int'(score), 0);
        chk("lines_after_new_game", int'(lines_total), 0);
        repeat (20) @(negedge frame_clk);
        chk("still_idle_after_new_game", int'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, e1;
        Reset_n = 1'b0;
        repeat (3) @(negedge frame_clk);
        Reset_n = 1'b1;
        #1;
        chk("reset_score", int'(score), 0);
        chk("reset_lines", int'(lines_total), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(clear_ready), 1);
        mon_en = 1'b1;

        // Four-line event: 8 points, 4 lines
        offer(3'd4, a);
        expect_single(a, 8, 4, 0, 0);
`ifdef SCORE_COUNTUP_EN
        wait_until(a + 17);
        chk("busy_before_last_step", int'(busy), 1);
        wait_until(a + 18);
        chk("busy_after_last_step", int'(busy), 0);
`else
        wait_until(a + 1);
        chk("busy_after_accept", int'(busy), 1);
        wait_until(a + 3);
        chk("busy_after_add", int'(busy), 0);
`endif
        wait_idle();

        // Two lines: 3 points
        offer(3'd2, a);
        expect_single(a, 3, 2, 8, 4);
        wait_idle();

        // Seven lines clamps to four: 8 points, 4 lines, level becomes 1
        offer(3'd7, a);
        expect_single(a, 8, 4, 11, 6);
        wait_idle();
        chk("level_at_10_lines", int'(level), 1);

        // Zero-line event is consumed without effect
        offer(3'd0, a);
        chk("busy_zero_event", int'(busy), 1);
        wait_idle();
        chk("score_zero_event", int'(score), 19);

        pulse_new_game(1'b1);

        // Back-pressure: hold a one-line offer; edges E1, E2 accept, E3 refused, E4 accepts
        @(negedge frame_clk);
        clear_valid = 1'b1;
        lines_cleared = 3'd1;
        #1 chk("bp_ready_empty", int'(clear_ready), 1);
        @(posedge frame_clk);
        #1 e1 = cyc;
`ifdef SCORE_COUNTUP_EN
        exp_push(e1 + 2, 0, 1);
        exp_push(e1 + 4, 1, 1);
        exp_push(e1 + 5, 1, 2);
        exp_push(e1 + 7, 2, 2);
        exp_push(e1 + 8, 2, 3);
        exp_push(e1 + 10, 3, 3);
`else
        exp_push(e1 + 2, 1, 1);
        exp_push(e1 + 3, 2, 2);
        exp_push(e1 + 5, 3, 3);
`endif
        @(negedge frame_clk);
        #1 chk("bp_ready_one", int'(clear_ready), 1);
        @(negedge frame_clk);
        #1 chk("bp_ready_full", int'(clear_ready), 0);
        @(negedge frame_clk);
        #1 chk("bp_ready_after_pop", int'(clear_ready), 1);
        @(negedge frame_clk);
        clear_valid = 1'b0;
        wait_idle();
        chk("bp_score", int'(score), 3);
        chk("bp_lines", int'(lines_total), 3);

        // new_game while scoring with an event still queued
        offer(3'd4, a);
`ifdef SCORE_COUNTUP_EN
        exp_push(a + 2, 3, 7);
        exp_push(a + 4, 4, 7);
        exp_push(a + 6, 5, 7);
        exp_push(a + 8, 6, 7);
        wait_until(a + 8);
        clear_valid = 1'b1;
        lines_cleared = 3'd2;
        #1 chk("queue_second_ready", int'(clear_ready), 1);
`endif
        pulse_new_game(1'b1);

        // Saturation: 130 four-line events
        mon_en = 1'b0;
        for (int i = 0; i < 130; i++) offer(3'd4, a);
        wait_idle();
        chk("sat_score", int'(score), 999);
        chk("sat_lines", int'(lines_total), 520);
        chk("sat_level", int'(level), 15);
        chk("sat_max_seen", max_s, 999);

        chk("expectations_consumed", exp_q.size(), 0);
        repeat (2) @(negedge frame_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
